// File: rtl/finalprojsoc_pkg.sv
// finalprojsoc_pkg: shared types and constants for the finalprojsoc Avalon-MM command master
//   state_e    : command master FSM states
//   AVM_DATA_W : Avalon data width
//   BE_ALL     : full-word byteenable
package finalprojsoc_pkg;
   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;
   localparam int AVM_DATA_W = 32;
   localparam logic [3:0] BE_ALL = 4'hF;
endpackage

// File: rtl/finalprojsoc_sync_fifo.sv
// finalprojsoc_sync_fifo: single-clock FIFO, pointers carry an extra wrap bit
//   clk, reset       : clock, synchronous active-high reset (empties the FIFO)
//   push_i, wdata_i  : write enable and data; caller must not push when full
//   pop_i, rdata_o   : read enable; rdata_o shows the head entry combinationally
//   full_o, empty_o  : occupancy flags
module finalprojsoc_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);
   localparam int AW = $clog2(DEPTH);
   logic [AW:0]      wp_q, rp_q;
   logic [WIDTH-1:0] mem_q [DEPTH];
   always_ff @(posedge clk) begin
      if (reset) begin
         wp_q <= '0;
         rp_q <= '0;
      end else begin
         if (push_i) wp_q <= wp_q + 1'b1;
         if (pop_i) rp_q <= rp_q + 1'b1;
      end
   end
   always_ff @(posedge clk) if (push_i) mem_q[wp_q[AW-1:0]] <= wdata_i;
   assign rdata_o = mem_q[rp_q[AW-1:0]];
   assign empty_o = wp_q == rp_q;
   assign full_o  = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
endmodule

// File: rtl/finalprojsoc_avm_cmd_master.sv
// finalprojsoc_avm_cmd_master: queues single-word commands and issues each as one Avalon-MM transfer
//   cmd_*  : command intake (valid/ready), write flag, byte address, write payload
//   rsp_*  : one-cycle response pulse with read data and timeout error
//   busy   : commands queued or a transfer in flight
//   avm_*  : Avalon-MM initiator port, registered strobes, zero read latency
module finalprojsoc_avm_cmd_master
   import finalprojsoc_pkg::*;
#(
   parameter int ADDR_W     = 4,
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 255
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_W-1:0]     cmd_address,
   input  logic [AVM_DATA_W-1:0] cmd_writedata,
   output logic                  rsp_valid,
   output logic [AVM_DATA_W-1:0] rsp_readdata,
   output logic                  rsp_error,
   output logic                  busy,
   output logic [ADDR_W-1:0]     avm_address,
   output logic                  avm_read,
   output logic                  avm_write,
   output logic [AVM_DATA_W-1:0] avm_writedata,
   output logic [3:0]            avm_byteenable,
   input  logic                  avm_waitrequest,
   input  logic [AVM_DATA_W-1:0] avm_readdata
);
   localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam int FW = 1 + ADDR_W + AVM_DATA_W;
   state_e                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  rd_q, rd_d, wr_q, wr_d, err_q, err_d;
   logic [ADDR_W-1:0]     addr_q, addr_d;
   logic [AVM_DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
   logic [FW-1:0]         head;
   logic                  full, empty, pop, abort;
   finalprojsoc_sync_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (cmd_valid && !full),
      .wdata_i ({cmd_write, cmd_address, cmd_writedata}),
      .pop_i   (pop),
      .rdata_o (head),
      .full_o  (full),
      .empty_o (empty)
   );
   // This stalled cycle is the TIMEOUT-th one, so the strobe must not be held past it.
   assign abort = (TIMEOUT != 0) && avm_waitrequest && (cnt_q == CW'(TIMEOUT - 1));
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      pop     = 1'b0;
      unique case (state_q)
         IDLE: if (!empty) begin
            state_d = ISSUE;
            pop     = 1'b1;
            cnt_d   = '0;
            wr_d    = head[FW-1];
            rd_d    = !head[FW-1];
            addr_d  = head[FW-2 -: ADDR_W];
            wdata_d = head[FW-1] ? head[AVM_DATA_W-1:0] : '0;
            rdata_d = '0;
            err_d   = 1'b0;
         end
         ISSUE: if (!avm_waitrequest || abort) begin
            state_d = RESP;
            rd_d    = 1'b0;
            wr_d    = 1'b0;
            rdata_d = (rd_q && !avm_waitrequest) ? avm_readdata : '0;
            err_d   = avm_waitrequest;
         end else begin
            cnt_d = (cnt_q == CW'(TIMEOUT)) ? cnt_q : cnt_q + 1'b1;
         end
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end
   assign cmd_ready      = !full;
   assign busy           = !empty || state_q != IDLE;
   assign rsp_valid      = state_q == RESP;
   assign rsp_readdata   = rdata_q;
   assign rsp_error      = err_q;
   assign avm_read       = rd_q;
   assign avm_write      = wr_q;
   assign avm_address    = addr_q;
   assign avm_writedata  = wdata_q;
   assign avm_byteenable = (rd_q || wr_q) ? BE_ALL : 4'h0;
endmodule

// File: tb/tb_finalprojsoc_avm_cmd_master.sv
// tb_finalprojsoc_avm_cmd_master: directed and random checks of the command master against a queue model
module tb_finalprojsoc_avm_cmd_master;
   localparam int TO = 8;
   typedef struct {logic w; logic [3:0] a; logic [31:0] d;} cmd_t;
   typedef struct {logic [31:0] d; logic e;} rsp_t;
   logic        clk = 0, reset = 1;
   logic        cmd_valid = 0, cmd_ready, cmd_write = 0;
   logic [3:0]  cmd_address = 0;
   logic [31:0] cmd_writedata = 0;
   logic        rsp_valid, rsp_error, busy;
   logic [31:0] rsp_readdata;
   logic [3:0]  avm_address, avm_byteenable;
   logic        avm_read, avm_write, avm_waitrequest = 0;
   logic [31:0] avm_writedata, avm_readdata = 0;
   int n_chk = 0, n_fail = 0;
   cmd_t exp_cmd[$];
   rsp_t exp_rsp[$];
   cmd_t cur;
   logic in_xfer = 0;
   int k = 0, s = 0, next_stall = -1;
   logic [31:0] rd = 0, forced_rd = 0;
   bit force_rd = 0;
   finalprojsoc_avm_cmd_master #(.ADDR_W(4), .FIFO_DEPTH(4), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_address(cmd_address), .cmd_writedata(cmd_writedata),
      .rsp_valid(rsp_valid), .rsp_readdata(rsp_readdata), .rsp_error(rsp_error), .busy(busy),
      .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
      .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
      .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata)
   );
   always #5 clk = ~clk;
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   // One clock: at the falling edge check responses, then act as the Avalon slave.
   // A transfer stalled s cycles completes when s < TO, otherwise it aborts on its TO-th stall.
   task automatic step();
      logic st;
      rsp_t r;
      @(negedge clk);
      if (rsp_valid) begin
         if (exp_rsp.size() == 0) chk("rsp_unexpected", 32'(rsp_valid), 0);
         else begin
            r = exp_rsp.pop_front();
            chk("rsp_data", rsp_readdata, r.d);
            chk("rsp_err", 32'(rsp_error), 32'(r.e));
         end
      end
      st = avm_read | avm_write;
      chk("rw_excl", 32'(avm_read & avm_write), 0);
      chk("byteenable", 32'(avm_byteenable), st ? 32'hF : 32'h0);
      if (st && !in_xfer) begin
         if (exp_cmd.size() == 0) chk("xfer_unexpected", 32'(st), 0);
         else begin
            cur = exp_cmd.pop_front();
            in_xfer = 1;
            k = 0;
            s = next_stall >= 0 ? next_stall : int'($urandom_range(0, 9));
            next_stall = -1;
            rd = force_rd ? forced_rd : $urandom;
            force_rd = 0;
         end
      end else if (!st && in_xfer) begin
         chk("strobe_dropped", 32'(st), 1);
         in_xfer = 0;
      end
      if (in_xfer) begin
         chk("address", 32'(avm_address), 32'(cur.a));
         chk("write", 32'(avm_write), 32'(cur.w));
         chk("read", 32'(avm_read), 32'(!cur.w));
         if (cur.w) chk("writedata", avm_writedata, cur.d);
         avm_waitrequest = k < s;
         avm_readdata = (k < s) ? $urandom : rd;
         if (k >= s) begin
            r.d = cur.w ? 32'h0 : rd;
            r.e = 0;
            exp_rsp.push_back(r);
            in_xfer = 0;
         end else if (k == TO - 1) begin
            r.d = 0;
            r.e = 1;
            exp_rsp.push_back(r);
            in_xfer = 0;
         end
         k++;
      end else begin
         avm_waitrequest = 1'($urandom);
         avm_readdata = $urandom;
      end
   endtask
   task automatic offer(input logic w, input logic [3:0] a, input logic [31:0] d, output bit acc);
      cmd_t c;
      cmd_valid = 1;
      cmd_write = w;
      cmd_address = a;
      cmd_writedata = d;
      acc = cmd_ready;
      if (acc) begin
         c.w = w;
         c.a = a;
         c.d = d;
         exp_cmd.push_back(c);
      end
   endtask
   task automatic window(input int n, output int ns, output int nr, output logic [31:0] d, output logic e);
      ns = 0;
      nr = 0;
      d = 'x;
      e = 'x;
      repeat (n) begin
         step();
         cmd_valid = 0;
         ns += int'(avm_read | avm_write);
         if (rsp_valid) begin
            nr++;
            d = rsp_readdata;
            e = rsp_error;
         end
      end
   endtask
   task automatic drain();
      cmd_valid = 0;
      for (int i = 0; i < 400 && (busy || in_xfer || exp_cmd.size() != 0 || exp_rsp.size() != 0); i++) step();
      chk("drain_busy", 32'(busy), 0);
      chk("drain_cmds", exp_cmd.size(), 0);
      chk("drain_rsps", exp_rsp.size(), 0);
   endtask
   initial begin
      int ns, nr, nacc;
      logic [31:0] d;
      logic e;
      bit acc;
      step();
      step();
      chk("rst_cmd_ready", 32'(cmd_ready), 1);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_read", 32'(avm_read), 0);
      chk("rst_write", 32'(avm_write), 0);
      chk("rst_address", 32'(avm_address), 0);
      chk("rst_writedata", avm_writedata, 0);
      chk("rst_readdata", rsp_readdata, 0);
      chk("rst_error", 32'(rsp_error), 0);
      reset = 0;
      // zero-wait write: strobe one cycle, response two cycles after the push
      next_stall = 0;
      step();
      offer(1, 4'h0, 32'h0000_2ABC, acc);
      window(4, ns, nr, d, e);
      chk("t1_strobe_cycles", ns, 1);
      chk("t1_rsp_count", nr, 1);
      chk("t1_rsp_data", d, 0);
      chk("t1_rsp_err", 32'(e), 0);
      drain();
      // read with three wait states
      next_stall = 3;
      force_rd = 1;
      forced_rd = 32'h0000_1234;
      step();
      offer(0, 4'h0, 32'hDEAD_BEEF, acc);
      window(7, ns, nr, d, e);
      chk("t2_strobe_cycles", ns, 4);
      chk("t2_rsp_count", nr, 1);
      chk("t2_rsp_data", d, 32'h0000_1234);
      chk("t2_rsp_err", 32'(e), 0);
      drain();
      // stall one transfer and fill the FIFO behind it
      next_stall = 7;
      step();
      offer(1, 4'h1, 32'hA0, acc);
      step();
      cmd_valid = 0;
      step();
      nacc = 0;
      for (int i = 0; i < 5; i++) begin
         offer(i[0], 4'(i + 2), 32'hB0 + 32'(i), acc);
         if (acc) nacc++;
         step();
      end
      chk("t3_accepted", nacc, 4);
      chk("t3_ready_low", 32'(cmd_ready), 0);
      acc = 0;
      for (int i = 0; i < 40 && !acc; i++) begin
         offer(1, 4'h6, 32'hB4, acc);
         step();
      end
      cmd_valid = 0;
      chk("t3_last_accepted", 32'(acc), 1);
      drain();
      // timeout on a stuck write; the queued read must still go out
      next_stall = 20;
      step();
      offer(1, 4'h5, 32'hC5, acc);
      step();
      offer(0, 4'h6, 32'hC6, acc);
      window(10, ns, nr, d, e);
      chk("t4_strobe_cycles", ns, TO);
      chk("t4_rsp_count", nr, 1);
      chk("t4_rsp_data", d, 0);
      chk("t4_rsp_err", 32'(e), 1);
      drain();
      // reset in the middle of a transfer with two commands queued
      next_stall = 20;
      step();
      offer(0, 4'h2, 0, acc);
      step();
      offer(1, 4'h3, 32'hD3, acc);
      step();
      offer(1, 4'h4, 32'hD4, acc);
      step();
      cmd_valid = 0;
      reset = 1;
      exp_cmd.delete();
      exp_rsp.delete();
      in_xfer = 0;
      step();
      chk("t5_read", 32'(avm_read), 0);
      chk("t5_write", 32'(avm_write), 0);
      chk("t5_busy", 32'(busy), 0);
      chk("t5_cmd_ready", 32'(cmd_ready), 1);
      chk("t5_rsp_valid", 32'(rsp_valid), 0);
      reset = 0;
      repeat (5) begin
         step();
         chk("t5_idle_rsp", 32'(rsp_valid), 0);
         chk("t5_idle_busy", 32'(busy), 0);
      end
      // random traffic with random stalls, including timeouts
      repeat (1500) begin
         step();
         if ($urandom_range(0, 1) == 1) offer(1'($urandom), 4'($urandom), $urandom, acc);
         else cmd_valid = 0;
      end
      step();
      drain();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
